// File: rtl/axi_rd_responder.sv
// AXI4 read-only slave that answers bursts from an internal index-initialised word memory.
// Define AXI_RESP_WRAP_BURST_EN to add WRAP burst support; otherwise WRAP behaves as INCR.
module axi_rd_responder #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    input  logic [ADDR_WIDTH-1:0] s_araddr,
    input  logic [ID_WIDTH-1:0]   s_arid,
    input  logic [7:0]            s_arlen,
    input  logic [2:0]            s_arsize,
    input  logic [1:0]            s_arburst,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic [DATA_WIDTH-1:0] s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rlast,
    output logic [ID_WIDTH-1:0]   s_rid,
    input  logic                  ar_block,
    input  logic                  r_block
);

    localparam int unsigned BYTE_AW = $clog2(DATA_WIDTH / 8);
    localparam int unsigned WORD_AW = ADDR_WIDTH - BYTE_AW;
    localparam int unsigned WORDS   = (2 ** ADDR_WIDTH) / (DATA_WIDTH / 8);
    localparam int unsigned CALC_W  = ADDR_WIDTH + 16;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_RSVD  = 2'b11;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            burst_q, burst_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  rlast_q, rlast_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;

    logic [DATA_WIDTH-1:0] mem [WORDS];
    logic                  burst_err;
    logic [CALC_W-1:0]     step_w;
    logic [CALC_W-1:0]     incr_w;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  issue;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic [7:0]            issue_cnt;
    logic [WORD_AW-1:0]    issue_idx;

    // Read-only contents: each word holds its own index; reset never touches it.
    always_comb begin
        for (int i = 0; i < WORDS; i++) begin
            mem[i] = DATA_WIDTH'(unsigned'(i));
        end
    end

`ifdef AXI_RESP_WRAP_BURST_EN
    logic              is_wrap;
    logic              wrap_len_ok;
    logic [CALC_W-1:0] wrap_mask;

    always_comb begin
        is_wrap     = (burst_q == 2'b10);
        wrap_len_ok = (len_q == 8'd1) || (len_q == 8'd3) || (len_q == 8'd7) || (len_q == 8'd15);
        burst_err   = (size_q > 3'(BYTE_AW)) || (burst_q == BURST_RSVD) || (is_wrap && !wrap_len_ok);
    end
`else
    always_comb begin
        burst_err = (size_q > 3'(BYTE_AW)) || (burst_q == BURST_RSVD);
    end
`endif

    // Address of the beat following the current one.
    always_comb begin
        step_w    = CALC_W'(1) << size_q;
        incr_w    = CALC_W'(addr_q) + step_w;
        next_addr = ADDR_WIDTH'(incr_w);
        if (burst_q == BURST_FIXED) begin
            next_addr = addr_q;
        end
`ifdef AXI_RESP_WRAP_BURST_EN
        wrap_mask = ((CALC_W'(len_q) + CALC_W'(1)) << size_q) - CALC_W'(1);
        if (is_wrap && !burst_err) begin
            next_addr = ADDR_WIDTH'((CALC_W'(addr_q) & ~wrap_mask) | (incr_w & wrap_mask));
        end
`endif
    end

    assign s_arready = (state_q == IDLE) && !ar_block;

    // Next-state and registered R channel logic.
    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        addr_d     = addr_q;
        len_d      = len_q;
        size_d     = size_q;
        burst_d    = burst_q;
        cnt_d      = cnt_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rlast_d    = rlast_q;
        rid_d      = rid_q;
        issue      = 1'b0;
        issue_addr = addr_q;
        issue_cnt  = cnt_q;
        issue_idx  = '0;

        case (state_q)
            IDLE: begin
                if (s_arvalid && s_arready) begin
                    id_d    = s_arid;
                    addr_d  = s_araddr;
                    len_d   = s_arlen;
                    size_d  = s_arsize;
                    burst_d = s_arburst;
                    cnt_d   = 8'd0;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (rvalid_q) begin
                    if (s_rready) begin
                        if (rlast_q) begin
                            rvalid_d = 1'b0;
                            state_d  = IDLE;
                        end else begin
                            addr_d     = next_addr;
                            cnt_d      = 8'(cnt_q + 8'd1);
                            issue_addr = next_addr;
                            issue_cnt  = 8'(cnt_q + 8'd1);
                            if (r_block) begin
                                rvalid_d = 1'b0;
                            end else begin
                                issue = 1'b1;
                            end
                        end
                    end
                end else if (!r_block) begin
                    issue = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (issue) begin
            issue_idx = WORD_AW'(issue_addr >> BYTE_AW);
            rvalid_d  = 1'b1;
            rdata_d   = burst_err ? '0 : mem[issue_idx];
            rresp_d   = burst_err ? RESP_SLVERR : RESP_OKAY;
            rlast_d   = (issue_cnt == len_q);
            rid_d     = id_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= '0;
            rlast_q  <= 1'b0;
            rid_q    <= '0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            size_q   <= size_d;
            burst_q  <= burst_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            rlast_q  <= rlast_d;
            rid_q    <= rid_d;
        end
    end

    assign s_rvalid = rvalid_q;
    assign s_rdata  = rdata_q;
    assign s_rresp  = rresp_q;
    assign s_rlast  = rlast_q;
    assign s_rid    = rid_q;

endmodule
